text_buffer_writer: RTL and testbench

- Upstream feeder for the text overlay renderer. Owns the character array and the per-row direction bits that the renderer reads combinationally, i.e. its `string_in` and `string_dir` inputs.
- Game logic issues simple commands over a valid/ready handshake: write char, clear row, clear all, print decimal number, set row direction.
- Commands are executed by a small sequencer in the video clock domain.
- The outputs connect directly to the renderer.

---
 rtl/text_buffer_writer_if.sv | 31 +++
 rtl/text_buffer_writer.sv | 253 +++++++++++++++++++++++++
 tb/tb_text_buffer_writer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_buffer_writer_if.sv
// Command channel from game logic into the text buffer writer.
// The master drives the command and the writer answers with cmd_ready.
interface text_buffer_writer_if #(
    parameter int ROW_W = 5,
    parameter int COL_W = 5
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [ROW_W-1:0] cmd_row;
    logic [COL_W-1:0] cmd_col;
    logic [15:0]      cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_row,
        output cmd_col,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_row,
        input  cmd_col,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/text_buffer_writer.sv
// Character array and row-direction owner for the text overlay renderer.
// Single-cycle writes run in IDLE; clears and decimal printing are sequenced.
module text_buffer_writer #(
    parameter int         STRING_ROWS = 19,
    parameter int         STRING_COLS = 30,
    parameter logic [7:0] FILL_CHAR   = 8'h20,
    parameter int         DEC_DIGITS  = 5
) (
    input  logic                                     vid_clk,
    input  logic                                     vid_reset_n,
    text_buffer_writer_if.slave                      cmd,
    output logic                                     busy,
    output logic [STRING_ROWS-1:0]                   string_dir,
    output logic [STRING_ROWS-1:0][STRING_COLS-1:0][7:0] string_out
);
    localparam int ROW_W = $clog2(STRING_ROWS);
    localparam int COL_W = $clog2(STRING_COLS);
    localparam int DIG_W = $clog2(DEC_DIGITS);
    localparam int BCD_W = 4 * DEC_DIGITS;

    localparam logic [ROW_W:0]   ROWS_LIM = (ROW_W+1)'(STRING_ROWS);
    localparam logic [COL_W:0]   COLS_LIM = (COL_W+1)'(STRING_COLS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(STRING_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(STRING_COLS - 1);
    localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(DEC_DIGITS - 1);

    localparam logic [2:0] OP_WRITE   = 3'd1;
    localparam logic [2:0] OP_CLR_ROW = 3'd2;
    localparam logic [2:0] OP_CLR_ALL = 3'd3;
    localparam logic [2:0] OP_PRINT   = 3'd4;
    localparam logic [2:0] OP_SET_DIR = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLR    = 2'd1,
        S_DABBLE = 2'd2,
        S_EMIT   = 2'd3
    } state_e;

    // Double-dabble correction: add 3 to every BCD nibble of 5 or more.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DEC_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = b[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Digit idx counts from the most significant nibble.
    function automatic logic [3:0] bcd_digit(input logic [BCD_W-1:0] b,
                                             input logic [DIG_W-1:0] idx);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < DEC_DIGITS; i++) begin
            if (idx == DIG_W'(i)) begin
                d = b[4*(DEC_DIGITS-1-i) +: 4];
            end else begin
                d = d;
            end
        end
        return d;
    endfunction

    state_e            state_r;
    state_e            next_state_s;
    logic [ROW_W-1:0]  row_r;
    logic [COL_W-1:0]  col_r;
    logic              clr_all_r;
    logic [15:0]       val_r;
    logic [BCD_W-1:0]  bcd_r;
    logic [3:0]        bit_cnt_r;
    logic [DIG_W-1:0]  digit_idx_r;
    logic              lead_r;

    logic              ready_s;
    logic              accept_s;
    logic              cmd_row_ok_s;
    logic              cmd_col_ok_s;
    logic              row_ok_s;
    logic              clr_done_s;
    logic [BCD_W-1:0]  bcd_adj_s;
    logic [3:0]        emit_digit_s;
    logic [COL_W:0]    emit_col_s;
    logic              emit_blank_s;
    logic              wr_en_s;
    logic [ROW_W-1:0]  wr_row_s;
    logic [COL_W-1:0]  wr_col_s;
    logic [7:0]        wr_data_s;

    assign accept_s     = cmd.cmd_valid && ready_s;
    assign cmd_row_ok_s = ({1'b0, cmd.cmd_row} < ROWS_LIM);
    assign cmd_col_ok_s = ({1'b0, cmd.cmd_col} < COLS_LIM);
    assign row_ok_s     = ({1'b0, row_r} < ROWS_LIM);
    assign clr_done_s   = (col_r == LAST_COL) && (!clr_all_r || (row_r == LAST_ROW));
    assign bcd_adj_s    = bcd_adjust(bcd_r);
    assign cmd.cmd_ready = ready_s;

    // State register.
    always_ff @(posedge vid_clk or negedge vid_reset_n) begin
        if (!vid_reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    case (cmd.cmd_op)
                        OP_CLR_ROW, OP_CLR_ALL: next_state_s = S_CLR;
                        OP_PRINT:               next_state_s = S_DABBLE;
                        default:                next_state_s = S_IDLE;
                    endcase
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_CLR: begin
                if (clr_done_s) next_state_s = S_IDLE;
                else            next_state_s = S_CLR;
            end
            S_DABBLE: begin
                if (bit_cnt_r == 4'd15) next_state_s = S_EMIT;
                else                    next_state_s = S_DABBLE;
            end
            S_EMIT: begin
                if (digit_idx_r == LAST_DIG) next_state_s = S_IDLE;
                else                         next_state_s = S_EMIT;
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        ready_s = (state_r == S_IDLE);
        busy    = ~ready_s;
    end

    // Single write port into the character array, shared by all operations.
    always_comb begin
        emit_digit_s = bcd_digit(bcd_r, digit_idx_r);
        emit_col_s   = {1'b0, col_r} + (COL_W+1)'(digit_idx_r);
        emit_blank_s = lead_r && (emit_digit_s == 4'd0) && (digit_idx_r != LAST_DIG);
        wr_en_s      = 1'b0;
        wr_row_s     = row_r;
        wr_col_s     = col_r;
        wr_data_s    = FILL_CHAR;
        case (state_r)
            S_IDLE: begin
                if (accept_s && (cmd.cmd_op == OP_WRITE)) begin
                    wr_en_s   = cmd_row_ok_s && cmd_col_ok_s;
                    wr_row_s  = cmd.cmd_row;
                    wr_col_s  = cmd.cmd_col;
                    wr_data_s = cmd.cmd_data[7:0];
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            S_CLR: begin
                wr_en_s = row_ok_s;
            end
            S_EMIT: begin
                // Digits past the last column are dropped rather than wrapped.
                wr_en_s   = row_ok_s && (emit_col_s < COLS_LIM);
                wr_col_s  = emit_col_s[COL_W-1:0];
                wr_data_s = emit_blank_s ? FILL_CHAR : (8'h30 + {4'h0, emit_digit_s});
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    // Sequencer counters and binary-to-BCD conversion registers.
    always_ff @(posedge vid_clk or negedge vid_reset_n) begin
        if (!vid_reset_n) begin
            row_r       <= '0;
            col_r       <= '0;
            clr_all_r   <= 1'b0;
            val_r       <= 16'd0;
            bcd_r       <= '0;
            bit_cnt_r   <= 4'd0;
            digit_idx_r <= '0;
            lead_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s && ((cmd.cmd_op == OP_CLR_ROW) || (cmd.cmd_op == OP_CLR_ALL))) begin
                        row_r     <= (cmd.cmd_op == OP_CLR_ALL) ? '0 : cmd.cmd_row;
                        col_r     <= '0;
                        clr_all_r <= (cmd.cmd_op == OP_CLR_ALL);
                    end else if (accept_s && (cmd.cmd_op == OP_PRINT)) begin
                        row_r       <= cmd.cmd_row;
                        col_r       <= cmd.cmd_col;
                        val_r       <= cmd.cmd_data;
                        bcd_r       <= '0;
                        bit_cnt_r   <= 4'd0;
                        digit_idx_r <= '0;
                        lead_r      <= 1'b1;
                    end
                end
                S_CLR: begin
                    if (col_r == LAST_COL) begin
                        col_r <= '0;
                        if (clr_all_r) row_r <= row_r + ROW_W'(1);
                    end else begin
                        col_r <= col_r + COL_W'(1);
                    end
                end
                S_DABBLE: begin
                    bcd_r     <= {bcd_adj_s[BCD_W-2:0], val_r[15]};
                    val_r     <= {val_r[14:0], 1'b0};
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                end
                S_EMIT: begin
                    digit_idx_r <= digit_idx_r + DIG_W'(1);
                    lead_r      <= lead_r && (emit_digit_s == 4'd0);
                end
                default: begin
                    row_r <= row_r;
                end
            endcase
        end
    end

    // Character array; reset also wipes any partially completed command.
    always_ff @(posedge vid_clk or negedge vid_reset_n) begin
        if (!vid_reset_n) begin
            string_out <= {(STRING_ROWS*STRING_COLS){FILL_CHAR}};
        end else if (wr_en_s) begin
            string_out[wr_row_s][wr_col_s] <= wr_data_s;
        end
    end

    // Per-row direction bits.
    always_ff @(posedge vid_clk or negedge vid_reset_n) begin
        if (!vid_reset_n) begin
            string_dir <= '0;
        end else if (accept_s && (cmd.cmd_op == OP_SET_DIR) && cmd_row_ok_s) begin
            string_dir[cmd.cmd_row] <= cmd.cmd_data[0];
        end
    end
endmodule

// File: tb/tb_text_buffer_writer.sv
// Directed bench for text_buffer_writer: one task per feature, hand-computed
// expectations plus a hand-maintained image of the character array.
module tb_text_buffer_writer;
    localparam int ROWS = 19;
    localparam int COLS = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic [ROWS-1:0] dir;
    logic [ROWS-1:0][COLS-1:0][7:0] sout;

    logic [7:0]      exp_mem [ROWS][COLS];
    logic [ROWS-1:0] exp_dir;
    int vectors = 0;
    int miscompares = 0;

    text_buffer_writer_if #(.ROW_W(5), .COL_W(5)) cmd_if();

    text_buffer_writer #(
        .STRING_ROWS(ROWS), .STRING_COLS(COLS), .FILL_CHAR(8'h20), .DEC_DIGITS(5)
    ) dut (
        .vid_clk(clk), .vid_reset_n(rst_n), .cmd(cmd_if),
        .busy(busy), .string_dir(dir), .string_out(sout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic fill_exp();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) exp_mem[r][c] = 8'h20;
        exp_dir = '0;
    endtask

    task automatic check_all(input string name);
        int bad; int fr; int fc;
        bad = 0; fr = 0; fc = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (sout[r][c] !== exp_mem[r][c]) begin
                    if (bad == 0) begin fr = r; fc = c; end
                    bad++;
                end
        vectors++;
        if (bad != 0 || dir !== exp_dir) begin
            miscompares++;
            $display("FAIL %s: %0d cells differ (first [%0d][%0d] got %h want %h), dir got %h want %h",
                     name, bad, fr, fc, sout[fr][fc], exp_mem[fr][fc], dir, exp_dir);
        end
    endtask

    // Issues one command and counts cycles with cmd_ready low afterwards.
    task automatic send(input logic [2:0] op, input logic [4:0] row, input logic [4:0] col,
                        input logic [15:0] data, output int cycles);
        int n;
        n = 0;
        while (!cmd_if.cmd_ready && n < 1000) begin @(posedge clk); #1; n++; end
        if (n >= 1000) begin
            vectors++; miscompares++;
            $display("FAIL send_wait: cmd_ready stuck low, got 0 want 1");
        end
        cmd_if.cmd_op = op; cmd_if.cmd_row = row; cmd_if.cmd_col = col; cmd_if.cmd_data = data;
        cmd_if.cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op = 3'd0; cmd_if.cmd_data = 16'hFFFF;
        cycles = 0;
        while (!cmd_if.cmd_ready && cycles < 2000) begin @(posedge clk); #1; cycles++; end
    endtask

    task automatic apply_reset();
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 3'd0;
        cmd_if.cmd_row = 5'd0; cmd_if.cmd_col = 5'd0; cmd_if.cmd_data = 16'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        fill_exp();
    endtask

    task automatic test_reset();
        apply_reset();
        check_all("reset_cells");
        vectors++;
        if (cmd_if.cmd_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_ready: got %b want 1", cmd_if.cmd_ready);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        cmd_if.cmd_op = 3'd1; cmd_if.cmd_row = 5'd3; cmd_if.cmd_col = 5'd7; cmd_if.cmd_data = 16'h0041;
        cmd_if.cmd_valid = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (sout[3][7] !== 8'h41 || cmd_if.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first: cell %h ready %b, want 41 ready 1", sout[3][7], cmd_if.cmd_ready);
        end
        cmd_if.cmd_col = 5'd8; cmd_if.cmd_data = 16'h0042;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        vectors++;
        if (sout[3][8] !== 8'h42) begin
            miscompares++; $display("FAIL b2b_second: got %h want 42", sout[3][8]);
        end
        exp_mem[3][7] = 8'h41; exp_mem[3][8] = 8'h42;
        check_all("b2b_array");
    endtask

    task automatic print_case(input logic [4:0] col, input logic [15:0] val,
                              input logic [39:0] exp_str, input string name);
        int cyc; int bad;
        send(3'd4, 5'd0, col, val, cyc);
        vectors++;
        if (cyc != 21) begin
            miscompares++; $display("FAIL %s_busy: got %0d cycles want 21", name, cyc);
        end
        bad = 0;
        for (int i = 0; i < 5; i++)
            if (int'(col) + i < COLS) begin
                exp_mem[0][int'(col) + i] = exp_str[8*(4-i) +: 8];
                if (sout[0][int'(col) + i] !== exp_str[8*(4-i) +: 8]) bad++;
            end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL %s_digits: %0d wrong, row0 got %h want \"%s\" from col %0d",
                     name, bad, sout[0], exp_str, col);
        end
    endtask

    task automatic test_print_dec();
        print_case(5'd0, 16'd1234, " 1234", "dec_1234");
        print_case(5'd0, 16'd0, "    0", "dec_0");
        print_case(5'd0, 16'd65535, "65535", "dec_65535");
        print_case(5'd27, 16'd54321, "54321", "dec_clip");
        check_all("dec_array");
    endtask

    task automatic test_clear_row();
        int cyc; int bad;
        cmd_if.cmd_op = 3'd1; cmd_if.cmd_row = 5'd5; cmd_if.cmd_data = 16'h0058;
        cmd_if.cmd_valid = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            cmd_if.cmd_col = 5'(c);
            @(posedge clk); #1;
        end
        cmd_if.cmd_row = 5'd4; cmd_if.cmd_col = 5'd0;  cmd_if.cmd_data = 16'h0059;
        @(posedge clk); #1;
        cmd_if.cmd_row = 5'd6; cmd_if.cmd_col = 5'd29; cmd_if.cmd_data = 16'h005A;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        for (int c = 0; c < COLS; c++) exp_mem[5][c] = 8'h58;
        exp_mem[4][0] = 8'h59; exp_mem[6][29] = 8'h5A;
        check_all("row_fill");
        send(3'd2, 5'd5, 5'd17, 16'd0, cyc);
        vectors++;
        if (cyc != 30) begin
            miscompares++; $display("FAIL clr_row_busy: got %0d cycles want 30", cyc);
        end
        bad = 0;
        for (int c = 0; c < COLS; c++) if (sout[5][c] !== 8'h20) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++; $display("FAIL clr_row_cells: %0d cells not 20, want 0", bad);
        end
        for (int c = 0; c < COLS; c++) exp_mem[5][c] = 8'h20;
        check_all("clr_row_array");
    endtask

    task automatic test_set_dir();
        int cyc;
        send(3'd5, 5'd18, 5'd0, 16'h0001, cyc);
        vectors++;
        if (dir !== 19'h40000 || cyc != 0) begin
            miscompares++; $display("FAIL set_dir18: got %h/%0d want 40000/0", dir, cyc);
        end
        send(3'd5, 5'd20, 5'd0, 16'h0001, cyc);
        vectors++;
        if (dir !== 19'h40000) begin
            miscompares++; $display("FAIL set_dir_oob: got %h want 40000", dir);
        end
        exp_dir = 19'h40000;
    endtask

    task automatic test_bounds();
        int cyc;
        send(3'd1, 5'd3, 5'd30, 16'h0057, cyc);
        send(3'd1, 5'd19, 5'd0, 16'h0057, cyc);
        send(3'd7, 5'd0, 5'd0, 16'h0052, cyc);
        vectors++;
        if (cyc != 0) begin
            miscompares++; $display("FAIL reserved_op: busy %0d cycles want 0", cyc);
        end
        send(3'd4, 5'd20, 5'd0, 16'd999, cyc);
        vectors++;
        if (cyc != 21) begin
            miscompares++; $display("FAIL dec_oob_busy: got %0d cycles want 21", cyc);
        end
        check_all("bounds_array");
    endtask

    task automatic test_clear_all();
        int cyc;
        send(3'd3, 5'd7, 5'd7, 16'd0, cyc);
        vectors++;
        if (cyc != 570) begin
            miscompares++; $display("FAIL clr_all_busy: got %0d cycles want 570", cyc);
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) exp_mem[r][c] = 8'h20;
        check_all("clr_all_array");
    endtask

    task automatic test_reset_mid();
        int cyc;
        send(3'd1, 5'd10, 5'd10, 16'h0051, cyc);
        cmd_if.cmd_op = 3'd3; cmd_if.cmd_row = 5'd0; cmd_if.cmd_col = 5'd0;
        cmd_if.cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL mid_busy: got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (cmd_if.cmd_ready !== 1'b1 || sout[10][10] !== 8'h20 || dir !== 19'h0) begin
            miscompares++;
            $display("FAIL mid_reset: ready %b cell %h dir %h want 1 20 0",
                     cmd_if.cmd_ready, sout[10][10], dir);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (cmd_if.cmd_ready !== 1'b1) begin
            miscompares++; $display("FAIL mid_release_ready: got %b want 1", cmd_if.cmd_ready);
        end
        fill_exp();
        check_all("mid_reset_array");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_print_dec();
        test_clear_row();
        test_set_dir();
        test_bounds();
        test_clear_all();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
